redmule_z_collector: RTL

REDMULE_Z_COLLECTOR -- requirements
Module: redmule_z_collector

---
 rtl/redmule_pkg.sv | 24 ++
 rtl/redmule_z_bank.sv | 36 +++
 rtl/redmule_z_collector.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared types and default geometry for the RedMulE Z-collector.
package redmule_pkg;

    localparam int unsigned ELEMS_DEF = 16;
    localparam int unsigned BITW_DEF  = 16;
    localparam int unsigned CNT_W     = $clog2(ELEMS_DEF + 1);

    typedef struct packed {
        logic [CNT_W-1:0] n_cols;
        logic [CNT_W-1:0] n_rows;
    } cntrl_zcollect_t;

    typedef struct packed {
        logic       empty;
        logic       full;
        logic [1:0] bank_valid;
    } flgs_zcollect_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_e;

endpackage

// File: rtl/redmule_z_bank.sv
// One ELEMS x ELEMS tile bank: column-wide write port, row-wide read port.
module redmule_z_bank
    import redmule_pkg::*;
#(
    parameter  int unsigned ELEMS = ELEMS_DEF,
    parameter  int unsigned BITW  = BITW_DEF,
    localparam int unsigned DW    = ELEMS * BITW,
    localparam int unsigned IDX_W = $clog2(ELEMS)
) (
    input  logic             clk_i,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_col,
    input  logic [DW-1:0]    i_wr_data,
    input  logic [IDX_W-1:0] i_rd_row,
    output logic [DW-1:0]    o_rd_data
);

    logic [BITW-1:0] r_mem [ELEMS][ELEMS];

    // Storage is deliberately reset-free; validity lives in the collector.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            for (int e = 0; e < ELEMS; e++) begin
                r_mem[e][i_wr_col] <= i_wr_data[e*BITW +: BITW];
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < ELEMS; c++) begin
            o_rd_data[c*BITW +: BITW] = r_mem[i_rd_row][c];
        end
    end

endmodule

// File: rtl/redmule_z_collector.sv
// Ping-pong tile buffer: collects engine result columns and streams the tile out row by row.
module redmule_z_collector
    import redmule_pkg::*;
#(
    parameter  int unsigned ELEMS  = ELEMS_DEF,
    parameter  int unsigned BITW   = BITW_DEF,
    localparam int unsigned DW     = ELEMS * BITW,
    localparam int unsigned STRB_W = DW / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              z_engine_valid_i,
    input  logic [DW-1:0]     z_engine_data_i,
    output logic              z_engine_ready_o,
    output logic              z_stream_valid_o,
    output logic [DW-1:0]     z_stream_data_o,
    output logic [STRB_W-1:0] z_stream_strb_o,
    input  logic              z_stream_ready_i,
    input  cntrl_zcollect_t   ctrl_i,
    output flgs_zcollect_t    flags_o
);

    localparam int unsigned IDX_W = $clog2(ELEMS);
    localparam int unsigned BPE   = BITW / 8;

    rd_state_e        r_state;
    logic [IDX_W-1:0] r_wr_col;
    logic [IDX_W-1:0] r_rd_row;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_bank_valid;
    logic [CNT_W-1:0] r_n_cols [2];
    logic [CNT_W-1:0] r_n_rows [2];

    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_first_col;
    logic [CNT_W-1:0] w_cur_ncols;
    logic             w_wr_last;
    logic             w_rd_last;
    logic [1:0]       w_bank_valid_nxt;
    logic             w_rd_bank_nxt;
    logic [DW-1:0]    w_rd_data [2];

    assign z_engine_ready_o = rst_ni & enable_i & ~clear_i & ~r_bank_valid[r_wr_bank];
    assign w_in_hs          = z_engine_valid_i & z_engine_ready_o;
    assign w_out_hs         = (r_state == R_DRAIN) & z_stream_ready_i;

    // Tile geometry comes straight from ctrl_i on the first column, then from the latched copy.
    assign w_first_col = (r_wr_col == '0);
    assign w_cur_ncols = w_first_col ? ctrl_i.n_cols : r_n_cols[r_wr_bank];
    assign w_wr_last   = w_in_hs & (CNT_W'(r_wr_col) == (w_cur_ncols - CNT_W'(1)));
    assign w_rd_last   = w_out_hs & (CNT_W'(r_rd_row) == (r_n_rows[r_rd_bank] - CNT_W'(1)));

    // Write-complete and drain-complete always target different banks, so both apply.
    always_comb begin
        w_bank_valid_nxt = r_bank_valid;
        if (w_wr_last) w_bank_valid_nxt[r_wr_bank] = 1'b1;
        if (w_rd_last) w_bank_valid_nxt[r_rd_bank] = 1'b0;
        w_rd_bank_nxt = r_rd_bank ^ w_rd_last;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= R_IDLE;
            r_wr_col     <= '0;
            r_rd_row     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_bank_valid <= '0;
            r_n_cols     <= '{default: CNT_W'(ELEMS)};
            r_n_rows     <= '{default: CNT_W'(ELEMS)};
        end else if (clear_i) begin
            r_state      <= R_IDLE;
            r_wr_col     <= '0;
            r_rd_row     <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_bank_valid <= '0;
        end else begin
            if (w_in_hs) begin
                if (w_first_col) begin
                    r_n_cols[r_wr_bank] <= ctrl_i.n_cols;
                    r_n_rows[r_wr_bank] <= ctrl_i.n_rows;
                end
                if (w_wr_last) begin
                    r_wr_col  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_col <= r_wr_col + IDX_W'(1);
                end
            end
            if (w_out_hs) begin
                r_rd_row <= w_rd_last ? '0 : r_rd_row + IDX_W'(1);
            end
            r_bank_valid <= w_bank_valid_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            // Looking at next-cycle validity gives latency 1 and no bubble between tiles.
            case (r_state)
                R_IDLE:  if (w_bank_valid_nxt[w_rd_bank_nxt]) r_state <= R_DRAIN;
                R_DRAIN: if (w_rd_last && !w_bank_valid_nxt[w_rd_bank_nxt]) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        redmule_z_bank #(
            .ELEMS (ELEMS),
            .BITW  (BITW)
        ) u_bank (
            .clk_i     (clk_i),
            .i_we      (w_in_hs && (r_wr_bank == 1'(b))),
            .i_wr_col  (r_wr_col),
            .i_wr_data (z_engine_data_i),
            .i_rd_row  (r_rd_row),
            .o_rd_data (w_rd_data[b])
        );
    end

    assign z_stream_valid_o = (r_state == R_DRAIN);
    assign z_stream_data_o  = r_rd_bank ? w_rd_data[1] : w_rd_data[0];

    always_comb begin
        z_stream_strb_o = '0;
        for (int c = 0; c < ELEMS; c++) begin
            if (CNT_W'(c) < r_n_cols[r_rd_bank]) z_stream_strb_o[c*BPE +: BPE] = '1;
        end
    end

    always_comb begin
        flags_o            = '0;
        flags_o.empty      = ~|r_bank_valid & (r_wr_col == '0);
        flags_o.full       = &r_bank_valid;
        flags_o.bank_valid = r_bank_valid;
    end

endmodule
